// File: rtl/keypad_event_encoder_pkg.sv
// Shared types and constants for the keypad event encoder and its consumers.
// Holds the FSM states, the scan-result kinds, the key-code map and the ALU opcodes.
package keypad_event_encoder_pkg;

  localparam int unsigned NUM_ROWS   = 4;
  localparam int unsigned NUM_COLS   = 4;
  localparam int unsigned KEY_CODE_W = 4;
  localparam int unsigned KEY_VAL_W  = 4;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_DEBOUNCE = 3'd1,
    ST_PRESS    = 3'd2,
    ST_WAIT_REL = 3'd3,
    ST_REL_DB   = 3'd4
  } kp_state_e;

  typedef enum logic [1:0] {
    SCAN_NONE   = 2'd0,
    SCAN_SINGLE = 2'd1,
    SCAN_MULTI  = 2'd2
  } scan_kind_e;

  typedef enum logic [1:0] {
    KEY_NUM = 2'd0,
    KEY_OP  = 2'd1,
    KEY_CLR = 2'd2,
    KEY_EQ  = 2'd3
  } key_class_e;

  // Opcodes shared with the ALU and operator save logic.
  localparam logic [1:0] OPC_ADD = 2'b00;
  localparam logic [1:0] OPC_SUB = 2'b01;
  localparam logic [1:0] OPC_MUL = 2'b10;
  localparam logic [1:0] OPC_DIV = 2'b11;

  // Key codes are {row[1:0], col[1:0]}.
  localparam logic [3:0] KC_1   = 4'h0;
  localparam logic [3:0] KC_2   = 4'h1;
  localparam logic [3:0] KC_3   = 4'h2;
  localparam logic [3:0] KC_ADD = 4'h3;
  localparam logic [3:0] KC_4   = 4'h4;
  localparam logic [3:0] KC_5   = 4'h5;
  localparam logic [3:0] KC_6   = 4'h6;
  localparam logic [3:0] KC_SUB = 4'h7;
  localparam logic [3:0] KC_7   = 4'h8;
  localparam logic [3:0] KC_8   = 4'h9;
  localparam logic [3:0] KC_9   = 4'hA;
  localparam logic [3:0] KC_MUL = 4'hB;
  localparam logic [3:0] KC_CLR = 4'hC;
  localparam logic [3:0] KC_0   = 4'hD;
  localparam logic [3:0] KC_EQ  = 4'hE;
  localparam logic [3:0] KC_DIV = 4'hF;

  typedef struct packed {
    key_class_e            cls;
    logic [KEY_VAL_W-1:0]  val;
  } key_info_t;

  function automatic key_info_t key_decode(input logic [KEY_CODE_W-1:0] code);
    key_info_t k;
    k.cls = KEY_NUM;
    k.val = 4'h0;
    case (code)
      KC_1:   k.val = 4'd1;
      KC_2:   k.val = 4'd2;
      KC_3:   k.val = 4'd3;
      KC_4:   k.val = 4'd4;
      KC_5:   k.val = 4'd5;
      KC_6:   k.val = 4'd6;
      KC_7:   k.val = 4'd7;
      KC_8:   k.val = 4'd8;
      KC_9:   k.val = 4'd9;
      KC_0:   k.val = 4'd0;
      KC_ADD: begin k.cls = KEY_OP; k.val = {2'b00, OPC_ADD}; end
      KC_SUB: begin k.cls = KEY_OP; k.val = {2'b00, OPC_SUB}; end
      KC_MUL: begin k.cls = KEY_OP; k.val = {2'b00, OPC_MUL}; end
      KC_DIV: begin k.cls = KEY_OP; k.val = {2'b00, OPC_DIV}; end
      KC_CLR: k.cls = KEY_CLR;
      KC_EQ:  k.cls = KEY_EQ;
      default: k.cls = KEY_NUM;
    endcase
    return k;
  endfunction

endpackage

// File: rtl/keypad_event_encoder_col_scanner.sv
// Column driver, row synchronizer and per-scan result encoder for a 4x4 keypad.
// Emits one scan_valid clock per full scan with kind none/single/multi and the single-key code.
module keypad_col_scanner
  import keypad_event_encoder_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 1000
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [NUM_ROWS-1:0]   row,
  output logic [NUM_COLS-1:0]   col,
  output logic                  scan_valid,
  output scan_kind_e            scan_kind,
  output logic [KEY_CODE_W-1:0] scan_code
);

  localparam int unsigned DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [NUM_ROWS-1:0]   row_meta;
  logic [NUM_ROWS-1:0]   row_sync;
  logic [DIV_W-1:0]      div_cnt;
  logic [1:0]            col_idx;
  logic [1:0]            hit_cnt;   // 2 means two or more keys seen this scan
  logic [KEY_CODE_W-1:0] hit_code;

  logic                  slot_end_c;
  logic [NUM_ROWS-1:0]   pressed_c;
  logic [2:0]            row_hits_c;
  logic [2:0]            sum_c;
  logic [1:0]            row_idx_c;
  logic [1:0]            hit_cnt_nxt_c;
  logic [KEY_CODE_W-1:0] hit_code_nxt_c;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      row_meta <= '1;
      row_sync <= '1;
    end else begin
      row_meta <= row;
      row_sync <= row_meta;
    end
  end

  assign slot_end_c = (div_cnt == DIV_W'(SCAN_DIV - 1));

  // Fold the current column's rows into the running per-scan tally.
  always_comb begin
    pressed_c  = ~row_sync;
    row_hits_c = 3'(pressed_c[0]) + 3'(pressed_c[1]) + 3'(pressed_c[2]) + 3'(pressed_c[3]);
    row_idx_c  = 2'd0;
    for (int r = NUM_ROWS - 1; r >= 0; r--) begin
      if (pressed_c[r]) row_idx_c = 2'(r);
    end
    sum_c          = 3'(hit_cnt) + row_hits_c;
    hit_cnt_nxt_c  = (sum_c >= 3'd2) ? 2'd2 : sum_c[1:0];
    hit_code_nxt_c = ((hit_cnt == 2'd0) && (row_hits_c == 3'd1)) ? {row_idx_c, col_idx} : hit_code;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      div_cnt    <= '0;
      col_idx    <= 2'd0;
      col        <= 4'b1110;
      hit_cnt    <= 2'd0;
      hit_code   <= '0;
      scan_valid <= 1'b0;
      scan_kind  <= SCAN_NONE;
      scan_code  <= '0;
    end else begin
      scan_valid <= 1'b0;
      if (slot_end_c) begin
        div_cnt <= '0;
        col_idx <= col_idx + 2'd1;
        col     <= {col[NUM_COLS-2:0], col[NUM_COLS-1]};
        if (col_idx == 2'd3) begin
          hit_cnt    <= 2'd0;
          hit_code   <= '0;
          scan_valid <= 1'b1;
          scan_code  <= hit_code_nxt_c;
          if (hit_cnt_nxt_c == 2'd0)      scan_kind <= SCAN_NONE;
          else if (hit_cnt_nxt_c == 2'd1) scan_kind <= SCAN_SINGLE;
          else                            scan_kind <= SCAN_MULTI;
        end else begin
          hit_cnt  <= hit_cnt_nxt_c;
          hit_code <= hit_code_nxt_c;
        end
      end else begin
        div_cnt <= div_cnt + DIV_W'(1);
      end
    end
  end

endmodule

// File: rtl/keypad_event_encoder.sv
// 4x4 keypad front end: debounces scan results and emits one key-event pulse per press.
// Chords and bounce are rejected; a key must be released for DB_SCANS scans before the next event.
module keypad_event_encoder
  import keypad_event_encoder_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 1000,
  parameter int unsigned DB_SCANS = 4
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic [NUM_ROWS-1:0]  row,
  output logic [NUM_COLS-1:0]  col,
  output logic                 num,
  output logic                 OP,
  output logic                 C,
  output logic                 EQ,
  output logic [KEY_VAL_W-1:0] key_val
);

  localparam int unsigned DB_W = $clog2(DB_SCANS + 1);

  logic                  scan_valid;
  scan_kind_e            scan_kind;
  logic [KEY_CODE_W-1:0] scan_code;

  kp_state_e             state, state_nxt;
  logic [DB_W-1:0]       dbcnt, dbcnt_nxt;
  logic [KEY_CODE_W-1:0] code_q, code_nxt;
  logic                  num_nxt, op_nxt, c_nxt, eq_nxt;
  logic [KEY_VAL_W-1:0]  key_val_nxt;
  logic [DB_W-1:0]       dbcnt_inc_c;
  logic                  db_done_c;
  key_info_t             info_c;

  keypad_col_scanner #(
    .SCAN_DIV (SCAN_DIV)
  ) u_scanner (
    .clk        (clk),
    .resetn     (resetn),
    .row        (row),
    .col        (col),
    .scan_valid (scan_valid),
    .scan_kind  (scan_kind),
    .scan_code  (scan_code)
  );

  assign dbcnt_inc_c = dbcnt + DB_W'(1);
  assign db_done_c   = (dbcnt_inc_c == DB_W'(DB_SCANS));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= ST_IDLE;
      dbcnt   <= '0;
      code_q  <= '0;
      num     <= 1'b0;
      OP      <= 1'b0;
      C       <= 1'b0;
      EQ      <= 1'b0;
      key_val <= '0;
    end else begin
      state   <= state_nxt;
      dbcnt   <= dbcnt_nxt;
      code_q  <= code_nxt;
      num     <= num_nxt;
      OP      <= op_nxt;
      C       <= c_nxt;
      EQ      <= eq_nxt;
      key_val <= key_val_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    dbcnt_nxt   = dbcnt;
    code_nxt    = code_q;
    key_val_nxt = key_val;
    num_nxt     = 1'b0;
    op_nxt      = 1'b0;
    c_nxt       = 1'b0;
    eq_nxt      = 1'b0;

    case (state)
      ST_IDLE: begin
        if (scan_valid && (scan_kind == SCAN_SINGLE)) begin
          code_nxt  = scan_code;
          dbcnt_nxt = DB_W'(1);
          state_nxt = (DB_SCANS == 1) ? ST_PRESS : ST_DEBOUNCE;
        end
      end
      ST_DEBOUNCE: begin
        if (scan_valid) begin
          if ((scan_kind == SCAN_SINGLE) && (scan_code == code_q)) begin
            dbcnt_nxt = dbcnt_inc_c;
            if (db_done_c) state_nxt = ST_PRESS;
          end else begin
            state_nxt = ST_IDLE;
          end
        end
      end
      ST_PRESS: state_nxt = ST_WAIT_REL;
      ST_WAIT_REL: begin
        if (scan_valid && (scan_kind == SCAN_NONE)) begin
          dbcnt_nxt = DB_W'(1);
          state_nxt = (DB_SCANS == 1) ? ST_IDLE : ST_REL_DB;
        end
      end
      ST_REL_DB: begin
        if (scan_valid) begin
          if (scan_kind == SCAN_NONE) begin
            dbcnt_nxt = dbcnt_inc_c;
            if (db_done_c) state_nxt = ST_IDLE;
          end else begin
            state_nxt = ST_WAIT_REL;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase

    // Event registers load on PRESS entry so the pulse coincides with the PRESS clock.
    info_c = key_decode(code_nxt);
    if (state_nxt == ST_PRESS) begin
      num_nxt     = (info_c.cls == KEY_NUM);
      op_nxt      = (info_c.cls == KEY_OP);
      c_nxt       = (info_c.cls == KEY_CLR);
      eq_nxt      = (info_c.cls == KEY_EQ);
      key_val_nxt = info_c.val;
    end
  end

endmodule

// File: tb/tb_keypad_event_encoder.sv
// Bench for keypad_event_encoder: keypad matrix model plus a scan-level reference model of press/release rules.
module tb_keypad_event_encoder;

  localparam int unsigned SCAN_DIV  = 4;
  localparam int unsigned DB_SCANS  = 3;
  localparam int unsigned SCAN_CLKS = 4 * SCAN_DIV;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic [3:0] row;
  logic [3:0] col;
  logic       num, OP, C, EQ;
  logic [3:0] key_val;
  logic [15:0] keys = '0;

  int tests = 0;
  int fails = 0;

  // Reference model state: scan-granular view of the press/release rules.
  int         run_len, run_code, none_len;
  bit         armed;
  bit         pend_valid;
  logic [3:0] pend_ev, pend_val;
  logic [3:0] exp_kv, exp_ev, exp_col;
  string      keymap = "123+456-789*C0=/";

  always #5 clk = ~clk;

  // Passive matrix: a pressed key pulls its row low while its column is driven.
  always_comb begin
    row = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !col[c]) row[r] = 1'b0;
  end

  keypad_event_encoder #(
    .SCAN_DIV (SCAN_DIV),
    .DB_SCANS (DB_SCANS)
  ) dut (
    .clk     (clk),
    .resetn  (resetn),
    .row     (row),
    .col     (col),
    .num     (num),
    .OP      (OP),
    .C       (C),
    .EQ      (EQ),
    .key_val (key_val)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    run_len = 0; run_code = -1; none_len = 0; armed = 1'b1;
    pend_valid = 1'b0; pend_ev = 4'h0; pend_val = 4'h0; exp_kv = 4'h0;
  endtask

  // Event bits are {num, OP, C, EQ}.
  task automatic decode(input int code, output logic [3:0] ev, output logic [3:0] val);
    byte ch;
    ch = keymap[code];
    ev = 4'b1000; val = 4'h0;
    if (ch >= "0" && ch <= "9") val = 4'(ch - "0");
    else if (ch == "+") begin ev = 4'b0100; val = 4'd0; end
    else if (ch == "-") begin ev = 4'b0100; val = 4'd1; end
    else if (ch == "*") begin ev = 4'b0100; val = 4'd2; end
    else if (ch == "/") begin ev = 4'b0100; val = 4'd3; end
    else if (ch == "C") ev = 4'b0010;
    else                ev = 4'b0001;
  endtask

  task automatic model_scan(input logic [15:0] k);
    int n;
    int code;
    n = $countones(k);
    code = -1;
    pend_valid = 1'b0;
    if (n == 1) for (int i = 0; i < 16; i++) if (k[i]) code = i;
    if (armed) begin
      // A single breaking a run is discarded; only the next identical single restarts it.
      if (n == 1 && (run_len == 0 || code == run_code)) begin
        run_code = code; run_len++;
      end else run_len = 0;
      if (run_len == int'(DB_SCANS)) begin
        armed = 1'b0; run_len = 0; none_len = 0; pend_valid = 1'b1;
        decode(code, pend_ev, pend_val);
      end
    end else begin
      if (n == 0) none_len++; else none_len = 0;
      if (none_len == int'(DB_SCANS)) begin armed = 1'b1; none_len = 0; run_len = 0; end
    end
  endtask

  // One full scan window with a fixed key set; abort_at >= 0 asserts reset mid-window.
  task automatic step_scan(input logic [15:0] k, input int abort_at);
    bit         cur_valid;
    logic [3:0] cur_ev, cur_val;
    keys = k;
    cur_valid = pend_valid; cur_ev = pend_ev; cur_val = pend_val;
    model_scan(k);
    for (int i = 0; i < int'(SCAN_CLKS); i++) begin
      @(posedge clk); #1;
      exp_ev = 4'h0;
      if (i == 0 && cur_valid) begin exp_ev = cur_ev; exp_kv = cur_val; end
      exp_col = ~(4'b0001 << (((i + 1) / int'(SCAN_DIV)) % 4));
      check("event_pulses", {4'h0, num, OP, C, EQ}, {4'h0, exp_ev});
      check("key_val", {4'h0, key_val}, {4'h0, exp_kv});
      check("col", {4'h0, col}, {4'h0, exp_col});
      if (i == abort_at) begin
        #2 resetn = 1'b0;
        #1;
        check("rst_pulses", {4'h0, num, OP, C, EQ}, 8'h00);
        check("rst_key_val", {4'h0, key_val}, 8'h00);
        check("rst_col", {4'h0, col}, 8'h0E);
        return;
      end
    end
  endtask

  task automatic repeat_scan(input logic [15:0] k, input int n);
    for (int j = 0; j < n; j++) step_scan(k, -1);
  endtask

  function automatic logic [15:0] key_bit(input int idx);
    logic [15:0] v;
    v = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  initial begin
    logic [15:0] cur;
    int r;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("reset_pulses", {4'h0, num, OP, C, EQ}, 8'h00);
    check("reset_key_val", {4'h0, key_val}, 8'h00);
    check("reset_col", {4'h0, col}, 8'h0E);
    @(negedge clk) resetn = 1'b1;

    // Idle scanning, then '7' held long, then release.
    repeat_scan(16'h0000, 3);
    repeat_scan(key_bit(8), 10);
    repeat_scan(16'h0000, 4);

    // '*' bouncing before settling.
    step_scan(key_bit(11), -1);
    step_scan(16'h0000, -1);
    repeat_scan(key_bit(11), 5);
    repeat_scan(16'h0000, 4);

    // '=' then a too-short release before 'C', then a full release and 'C' again.
    repeat_scan(key_bit(14), 4);
    step_scan(16'h0000, -1);
    repeat_scan(key_bit(12), 4);
    repeat_scan(16'h0000, 4);
    repeat_scan(key_bit(12), 4);
    repeat_scan(16'h0000, 4);

    // '5'+'9' chord, then '9' released while '5' held.
    repeat_scan(key_bit(5) | key_bit(10), 4);
    repeat_scan(key_bit(5), 4);
    repeat_scan(16'h0000, 4);

    // Two keys on one row (different columns) are also a chord.
    repeat_scan(key_bit(0) | key_bit(3), 4);
    repeat_scan(16'h0000, 4);

    // Reset while DEBOUNCE holds two matching scans; count must restart.
    repeat_scan(key_bit(1), 2);
    step_scan(key_bit(1), 5);
    repeat (3) @(posedge clk);
    model_reset();
    @(negedge clk) resetn = 1'b1;
    repeat_scan(key_bit(1), 4);
    repeat_scan(16'h0000, 4);

    // Randomized key activity against the reference model.
    cur = '0;
    for (int s = 0; s < 160; s++) begin
      r = $urandom_range(0, 99);
      if (r < 55)      cur = cur;
      else if (r < 78) cur = '0;
      else if (r < 94) cur = key_bit($urandom_range(0, 15));
      else             cur = key_bit($urandom_range(0, 15)) | key_bit($urandom_range(0, 15));
      step_scan(cur, -1);
    end
    repeat_scan(16'h0000, 4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
